// File: rtl/bus_arbiter_rr.sv
// Four-master round-robin bus arbiter with tenure limit
// and slave-ready timeout watchdog.
module bus_arbiter_rr #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic       clk,
  input  logic       reset_,
  input  logic [3:0] mReq_,
  output logic [3:0] mGrnt_,
  input  logic       sAs_,
  input  logic       sRdy_,
  output logic       toRdy_,
  output logic       busErr,
  output logic [1:0] errOwner,
  output logic [7:0] errCnt,
  output logic [1:0] owner,
  output logic       ownerValid
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    XFER,
    TOUT
  } state_e;

  localparam logic [7:0] HOLD_MAX  = 8'(MAX_HOLD);
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [9:0] TO_MAX    = 10'(TIMEOUT);

  state_e     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [3:0] grnt_q, grnt_d;
  logic [7:0] hold_q, hold_d;
  logic [9:0] to_q, to_d;
  logic [1:0] eown_q, eown_d;
  logic [7:0] ecnt_q, ecnt_d;
  logic       tordy_q, tordy_d;
  logic       berr_q, berr_d;

  logic [3:0] req;
  logic [3:0] others;
  logic [7:0] hold_inc;

  // First requester after base, wrapping back to base last.
  function automatic logic [1:0] rr_pick(
    input logic [3:0] r,
    input logic [1:0] base
  );
    logic [1:0] idx;
    logic       found;
    rr_pick = base;
    found   = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = base + 2'(i);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign req      = ~mReq_;
  assign others   = req & ~(4'b0001 << owner_q);
  assign hold_inc = (hold_q >= HOLD_MAX) ? hold_q
                                         : hold_q + 8'd1;

  // Next-state, ownership, tenure and watchdog decisions.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    to_d    = to_q;
    eown_d  = eown_q;
    ecnt_d  = ecnt_q;
    unique case (state_q)
      IDLE: begin
        hold_d = 8'd0;
        if (|req) begin
          state_d = GRANT;
          owner_d = rr_pick(req, owner_q);
        end
      end
      GRANT: begin
        if (!sAs_) begin
          hold_d = hold_inc;
          if (sRdy_) begin
            state_d = XFER;
            to_d    = 10'd1;
          end
        end else if (!req[owner_q]) begin
          hold_d = 8'd0;
          if (|others) begin
            owner_d = rr_pick(others, owner_q);
          end else begin
            state_d = IDLE;
          end
        end else if (hold_q >= HOLD_LAST
                     && |others) begin
          owner_d = rr_pick(others, owner_q);
          hold_d  = 8'd0;
        end else begin
          hold_d = hold_inc;
        end
      end
      XFER: begin
        hold_d = hold_inc;
        if (!sRdy_) begin
          state_d = GRANT;
          to_d    = 10'd0;
        end else if (to_q >= TO_MAX) begin
          state_d = TOUT;
          eown_d  = owner_q;
          if (ecnt_q != 8'hFF) begin
            ecnt_d = ecnt_q + 8'd1;
          end
        end else begin
          to_d = to_q + 10'd1;
        end
      end
      TOUT: begin
        state_d = GRANT;
        to_d    = 10'd0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered grant and termination outputs follow next state.
  always_comb begin
    grnt_d  = 4'hF;
    tordy_d = 1'b1;
    berr_d  = 1'b0;
    if (state_d != IDLE) begin
      grnt_d = ~(4'b0001 << owner_d);
    end
    if (state_d == TOUT) begin
      tordy_d = 1'b0;
      berr_d  = 1'b1;
    end
  end

  // State and output registers; reset drops the grant at once.
  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      state_q <= IDLE;
      owner_q <= 2'd3;
      grnt_q  <= 4'hF;
      hold_q  <= 8'd0;
      to_q    <= 10'd0;
      eown_q  <= 2'd0;
      ecnt_q  <= 8'd0;
      tordy_q <= 1'b1;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      grnt_q  <= grnt_d;
      hold_q  <= hold_d;
      to_q    <= to_d;
      eown_q  <= eown_d;
      ecnt_q  <= ecnt_d;
      tordy_q <= tordy_d;
      berr_q  <= berr_d;
    end
  end

  assign mGrnt_     = grnt_q;
  assign ownerValid = ~&grnt_q;
  assign owner      = owner_q;
  assign toRdy_     = tordy_q;
  assign busErr     = berr_q;
  assign errOwner   = eown_q;
  assign errCnt     = ecnt_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr against
// a cycle-level behavioural model of the arbitration rules.
module tb_bus_arbiter_rr;

  localparam int MAXH = 16;
  localparam int TMO  = 8;

  logic       clk = 1'b0;
  logic       reset_;
  logic [3:0] mReq_;
  logic [3:0] mGrnt_;
  logic       sAs_;
  logic       sRdy_;
  logic       toRdy_;
  logic       busErr;
  logic [1:0] errOwner;
  logic [7:0] errCnt;
  logic [1:0] owner;
  logic       ownerValid;

  int n_chk = 0;
  int n_err = 0;

  // model: grant held, owner, tenure cycles served,
  // cycles waited on the slave, timeout cycle, error log
  bit m_gnt;
  int m_own;
  int m_ten;
  int m_wait;
  bit m_tout;
  int m_eown;
  int m_ecnt;

  bus_arbiter_rr #(
    .MAX_HOLD(MAXH),
    .TIMEOUT (TMO)
  ) dut (
    .clk       (clk),
    .reset_    (reset_),
    .mReq_     (mReq_),
    .mGrnt_    (mGrnt_),
    .sAs_      (sAs_),
    .sRdy_     (sRdy_),
    .toRdy_    (toRdy_),
    .busErr    (busErr),
    .errOwner  (errOwner),
    .errCnt    (errCnt),
    .owner     (owner),
    .ownerValid(ownerValid)
  );

  always #5 clk = ~clk;

  wire [18:0] dut_vec = {mGrnt_, owner, ownerValid,
                         toRdy_, busErr, errOwner, errCnt};

  function automatic logic [18:0] exp_vec();
    logic [3:0] g;
    g = 4'hF;
    if (m_gnt) g[m_own] = 1'b0;
    return {g, 2'(m_own), m_gnt, ~m_tout, m_tout,
            2'(m_eown), 8'(m_ecnt)};
  endfunction

  task automatic model_reset();
    m_gnt  = 0;
    m_own  = 3;
    m_ten  = 0;
    m_wait = 0;
    m_tout = 0;
    m_eown = 0;
    m_ecnt = 0;
  endtask

  // first requester in the order base+1, base+2, base+3, base
  function automatic int pick(bit [3:0] r, int base);
    for (int k = 1; k <= 4; k++) begin
      if (r[(base + k) % 4]) return (base + k) % 4;
    end
    return base;
  endfunction

  // advance the model by one clock using the present inputs
  task automatic model_next();
    bit [3:0] rq;
    bit [3:0] oth;
    bit       g;
    int       o;
    int       w;
    bit       t;
    rq  = ~mReq_;
    oth = rq;
    oth[m_own] = 1'b0;
    g = m_gnt;
    o = m_own;
    w = m_wait;
    t = 0;
    if (!m_gnt) begin
      if (rq != 0) begin
        g = 1;
        o = pick(rq, m_own);
      end
    end else if (m_tout) begin
      w = 0;
    end else if (m_wait > 0) begin
      if (!sRdy_) w = 0;
      else if (m_wait >= TMO) begin
        t = 1;
        m_eown = m_own;
        if (m_ecnt < 255) m_ecnt++;
      end else w = m_wait + 1;
    end else if (!sAs_) begin
      if (sRdy_) w = 1;
    end else if (!rq[m_own] || m_ten >= MAXH) begin
      if (oth != 0) o = pick(oth, m_own);
      else if (!rq[m_own]) g = 0;
    end
    if (!g) m_ten = 0;
    else if (!m_gnt || o != m_own) m_ten = 1;
    else if (!t) m_ten = m_ten + 1;
    m_gnt  = g;
    m_own  = o;
    m_wait = w;
    m_tout = t;
  endtask

  task automatic step();
    model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_ = 1'b1;
    mReq_  = 4'hF;
    sAs_   = 1'b1;
    sRdy_  = 1'b1;
    model_reset();
    #1;
    n_chk++;
    if (dut_vec !== exp_vec()) begin
      n_err++;
      $display("FAIL reset: got %h want %h", dut_vec, exp_vec());
    end
    @(posedge clk);
    #1;
    reset_ = 1'b0;
    step();
    n_chk++;
    if (dut_vec !== exp_vec()) begin
      n_err++;
      $display("FAIL reset_idle: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_rotation();
    mReq_ = 4'b0000;
    step();
    n_chk++;
    if (dut_vec !== exp_vec() || mGrnt_ !== 4'b1110) begin
      n_err++;
      $display("FAIL rot_first: got %h want %h", dut_vec, exp_vec());
    end
    for (int i = 0; i < 4; i++) begin
      mReq_ = 4'b0001 << owner;
      step();
      n_chk++;
      if (dut_vec !== exp_vec() || owner !== 2'((i + 1) % 4)
          || ownerValid !== 1'b1) begin
        n_err++;
        $display("FAIL rot_%0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_single();
    logic [3:0] rq [5] = '{4'hF, 4'b1011, 4'b1011, 4'b1011, 4'hF};
    logic       as [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      mReq_ = rq[i];
      sAs_  = as[i];
      sRdy_ = as[i];
      step();
      n_chk++;
      if (dut_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL single_%0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    sAs_  = 1'b1;
    sRdy_ = 1'b1;
    step();
    n_chk++;
    if (mGrnt_ !== 4'hF || owner !== 2'd2 || ownerValid !== 1'b0) begin
      n_err++;
      $display("FAIL single_idle: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_preempt();
    int held;
    held  = 0;
    mReq_ = 4'b1100;
    for (int i = 0; i < 20; i++) begin
      step();
      if (mGrnt_ === 4'b1110) held++;
      n_chk++;
      if (dut_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL preempt_%0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    n_chk++;
    if (held != MAXH || mGrnt_ !== 4'b1101) begin
      n_err++;
      $display("FAIL preempt_len: got %0d want %0d", held, MAXH);
    end
  endtask

  task automatic test_deferred();
    mReq_ = 4'hF;
    step();
    mReq_ = 4'b1100;
    for (int i = 0; i < MAXH; i++) step();
    n_chk++;
    if (dut_vec !== exp_vec() || mGrnt_ !== 4'b1110) begin
      n_err++;
      $display("FAIL defer_start: got %h want %h", dut_vec, exp_vec());
    end
    sAs_  = 1'b0;
    sRdy_ = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      sAs_  = 1'b1;
      sRdy_ = (i == 3) ? 1'b0 : 1'b1;
      n_chk++;
      if (dut_vec !== exp_vec() || mGrnt_ !== 4'b1110) begin
        n_err++;
        $display("FAIL defer_hold_%0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    sRdy_ = 1'b1;
    step();
    n_chk++;
    if (dut_vec !== exp_vec() || mGrnt_ !== 4'b1101) begin
      n_err++;
      $display("FAIL defer_move: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_timeout();
    int at;
    int pulses;
    at     = -1;
    pulses = 0;
    mReq_  = 4'hF;
    step();
    mReq_ = 4'b1101;
    step();
    sAs_  = 1'b0;
    sRdy_ = 1'b1;
    step();
    sAs_ = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      step();
      if (busErr === 1'b1) begin
        pulses++;
        at = i;
      end
      n_chk++;
      if (dut_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL tout_%0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    n_chk++;
    if (pulses != 1 || at != TMO || errOwner !== 2'd1
        || errCnt !== 8'd1 || mGrnt_ !== 4'b1101) begin
      n_err++;
      $display("FAIL tout_pulse: got n=%0d at=%0d eo=%0d ec=%0d want n=1 at=%0d eo=1 ec=1",
               pulses, at, errOwner, errCnt, TMO);
    end
  endtask

  task automatic test_release_xfer();
    mReq_ = 4'hF;
    step();
    mReq_ = 4'b1011;
    step();
    mReq_ = 4'b0011;
    sAs_  = 1'b0;
    sRdy_ = 1'b1;
    step();
    mReq_ = 4'b0111;
    sAs_  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sRdy_ = (i == 4) ? 1'b0 : 1'b1;
      step();
      n_chk++;
      if (dut_vec !== exp_vec() || busErr !== 1'b0
          || mGrnt_ !== (i == 5 ? 4'b0111 : 4'b1011)) begin
        n_err++;
        $display("FAIL relx_%0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      mReq_ = 4'($urandom);
      sAs_  = ($urandom_range(0, 3) != 0);
      sRdy_ = ($urandom_range(0, 2) != 0);
      step();
      n_chk++;
      if (dut_vec !== exp_vec() || $countones(~mGrnt_) > 1) begin
        n_err++;
        $display("FAIL rand_%0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_reset_xfer();
    mReq_ = 4'b0000;
    sAs_  = 1'b0;
    sRdy_ = 1'b1;
    step();
    step();
    sAs_ = 1'b1;
    step();
    #3;
    reset_ = 1'b1;
    model_reset();
    #1;
    n_chk++;
    if (dut_vec !== exp_vec()) begin
      n_err++;
      $display("FAIL rst_xfer: got %h want %h", dut_vec, exp_vec());
    end
    @(posedge clk);
    #1;
    reset_ = 1'b0;
    mReq_  = 4'b0000;
    step();
    n_chk++;
    if (dut_vec !== exp_vec() || mGrnt_ !== 4'b1110) begin
      n_err++;
      $display("FAIL rst_regrant: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_single();
    test_preempt();
    test_deferred();
    test_timeout();
    test_release_xfer();
    test_random();
    test_reset_xfer();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
